// File: rtl/synapse_pkg.sv
// synapse_pkg: shared defaults, loader state and helpers for synapse_matrix_loader
package synapse_pkg;
  localparam int DEF_ROWS = 5;
  localparam int DEF_COLS = 3;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, CSUM} ld_state_t;
  function automatic int elem_lsb(input int k, input int w);
    return k * w;
  endfunction
  function automatic int unsigned csum_add(input int unsigned acc, input int unsigned e, input int w);
    return (acc + e) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/serial_elem_shift.sv
// serial_elem_shift: WIDTH-bit MSB-first shifter; elem includes the bit being taken this cycle
module serial_elem_shift #(
  parameter int WIDTH = 4,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] elem,
  output logic             elem_done
);
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt, cnt_b;
  // clr restarts the element in the same cycle, so a qualifying bit becomes bit 0
  assign cnt_b = clr ? '0 : cnt;
  assign elem = WIDTH'({sr, bit_in});
  assign elem_done = en && cnt_b == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      cnt <= '0;
    end else if (en) begin
      sr <= elem;
      cnt <= elem_done ? '0 : cnt_b + 1'b1;
    end else if (clr) begin
      cnt <= '0;
    end
endmodule

// File: rtl/synapse_matrix_loader.sv
// synapse_matrix_loader: serial MSB-first matrix loader with double-buffered phi_out.
// Define CHECKSUM_EN to require a trailing WIDTH-bit sum-of-elements checksum per frame.
module synapse_matrix_loader import synapse_pkg::*; #(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int WIDTH = DEF_WIDTH,
  localparam int N = ROWS * COLS,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 frame_start,
  output logic [N*WIDTH-1:0]   phi_out,
  output logic                 phi_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [IDXW-1:0]      elem_idx
);
  ld_state_t state, state_nx;
  logic [IDXW-1:0] idx;
  logic [N*WIDTH-1:0] staging, image;
  logic [WIDTH-1:0] elem;
  logic en, done, abort, last, elem_wr, pay_done, commit, err;
  assign en = bit_valid && (frame_start || state != IDLE);
  assign abort = frame_start && state != IDLE;
  assign last = idx == IDXW'(N - 1);
  assign elem_wr = done && state == SHIFT && !frame_start;
  assign pay_done = elem_wr && last;
  assign busy = state != IDLE;
  assign elem_idx = idx;
  serial_elem_shift #(.WIDTH(WIDTH)) u_shift (
    .clk(clk), .rst(rst), .clr(frame_start), .en(en), .bit_in(bit_in),
    .elem(elem), .elem_done(done)
  );
`ifdef CHECKSUM_EN
  localparam ld_state_t AFTER_PAY = CSUM;
  logic [WIDTH-1:0] acc;
  logic csum_done;
  assign csum_done = done && state == CSUM && !frame_start;
  assign commit = csum_done && elem == acc;
  assign err = abort || (csum_done && elem != acc);
  assign image = staging;
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (frame_start) acc <= '0;
    else if (elem_wr) acc <= WIDTH'(csum_add(32'(acc), 32'(elem), WIDTH));
`else
  localparam ld_state_t AFTER_PAY = IDLE;
  assign commit = pay_done;
  assign err = abort;
  // last element goes straight to phi_out without a staging round trip
  always_comb begin
    image = staging;
    image[elem_lsb(N - 1, WIDTH) +: WIDTH] = elem;
  end
`endif
  always_comb begin
    state_nx = state;
    if (frame_start) state_nx = SHIFT;
    else if (pay_done) state_nx = AFTER_PAY;
    else if (commit || err) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      staging <= '0;
      phi_out <= '0;
      phi_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      phi_valid <= commit;
      frame_err <= err;
      if (frame_start) idx <= '0;
      else if (elem_wr) begin
        staging[elem_lsb(int'(idx), WIDTH) +: WIDTH] <= elem;
        idx <= last ? '0 : idx + 1'b1;
      end
      if (commit) phi_out <= image;
    end
endmodule

// File: tb/tb_synapse_matrix_loader.sv
// tb_synapse_matrix_loader: randomized frames against a frame-level reference model
module tb_synapse_matrix_loader;
  localparam int R = 5, C = 3, W = 4, N = R * C, NW = N * W, IDXW = 4;
`ifdef CHECKSUM_EN
  localparam int TOT = NW + W;
`else
  localparam int TOT = NW;
`endif
  typedef logic [W-1:0] mat_t [N];
  logic clk = 0, rst = 0, bit_in = 0, bit_valid = 0, frame_start = 0;
  logic [NW-1:0] phi_out;
  logic phi_valid, frame_err, busy;
  logic [IDXW-1:0] elem_idx;
  int nvec = 0, nerr = 0;
  logic [NW-1:0] ref_phi = '0;
  bit in_frame = 0;
  always #5 clk = ~clk;
  synapse_matrix_loader dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
    .phi_out(phi_out), .phi_valid(phi_valid), .frame_err(frame_err), .busy(busy), .elem_idx(elem_idx)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic fs, input logic v, input logic b);
    @(negedge clk);
    frame_start = fs;
    bit_valid = v;
    bit_in = b;
    @(posedge clk);
    #1;
    frame_start = 0;
    bit_valid = 0;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_phi"}, 64'(phi_out), 64'd0);
    check({tag, "_pv"}, 64'(phi_valid), 64'd0);
    check({tag, "_fe"}, 64'(frame_err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_idx"}, 64'(elem_idx), 64'd0);
  endtask
  function automatic logic [W-1:0] msum(input mat_t m);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(m[k]);
    return W'(s);
  endfunction
  task automatic rand_mat(output mat_t m);
    for (int k = 0; k < N; k++) m[k] = W'($urandom);
  endtask
  // stall < 0 means bit_valid alternates 1,0,1,...; stop = number of bits sent before returning
  task automatic run_frame(input mat_t el, input logic [W-1:0] cs, input int stop, input int stall, output int ncyc);
    logic [NW-1:0] img;
    bit good, first, fin, v;
    logic b;
    int sent;
    for (int k = 0; k < N; k++) img[k*W +: W] = el[k];
    good = 1;
`ifdef CHECKSUM_EN
    good = (cs == msum(el));
`endif
    sent = 0;
    first = 1;
    ncyc = 0;
    while (sent < stop) begin
      v = first || (stall < 0 ? (ncyc % 2 == 0) : ($urandom_range(0, 99) >= stall));
      b = (sent < NW) ? el[sent / W][W - 1 - sent % W] : cs[W - 1 - (sent - NW) % W];
      if (!v) b = 1'($urandom);
      drive(first, v, b);
      ncyc++;
      if (v) sent++;
      fin = v && sent == TOT;
      check("frame_err", 64'(frame_err), 64'((first && in_frame) || (fin && !good)));
      in_frame = !fin;
      if (fin && good) ref_phi = img;
      check("phi_valid", 64'(phi_valid), 64'(fin && good));
      check("busy", 64'(busy), 64'(in_frame));
      check("elem_idx", 64'(elem_idx), 64'((in_frame && sent < NW) ? sent / W : 0));
      check("phi_out", 64'(phi_out), 64'(ref_phi));
      first = 0;
    end
  endtask
  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1'($urandom), 1'($urandom));
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_idx", 64'(elem_idx), 64'd0);
      check("idle_pv", 64'(phi_valid), 64'd0);
      check("idle_phi", 64'(phi_out), 64'(ref_phi));
    end
  endtask
  initial begin
    mat_t m, ones;
    int nc;
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 0;
    idle_bits(4);
    for (int k = 0; k < N; k++) m[k] = (k % 3 == 0) ? 4'hF : 4'h0;
    run_frame(m, msum(m), TOT, 0, nc);
    check("basic_image", 64'(phi_out), 64'({5{12'h00F}}));
    check("basic_cycles", 64'(nc), 64'(TOT));
    idle_bits(2);
    run_frame(m, msum(m), TOT, -1, nc);
    check("stall_cycles", 64'(nc), 64'(2 * TOT - 1));
    check("stall_image", 64'(phi_out), 64'({5{12'h00F}}));
    rand_mat(m);
    run_frame(m, msum(m), 30, 20, nc);
    for (int k = 0; k < N; k++) ones[k] = '1;
    run_frame(ones, msum(ones), TOT, 20, nc);
    check("abort_ones", 64'(phi_out), 64'({NW{1'b1}}));
    rand_mat(m);
    run_frame(m, msum(m), 20, 0, nc);
    @(negedge clk) rst = 1;
    #1 check_zero("midrst");
    @(posedge clk);
    @(negedge clk) rst = 0;
    in_frame = 0;
    ref_phi = '0;
    rand_mat(m);
    run_frame(m, msum(m), TOT, 10, nc);
    idle_bits(3);
    rand_mat(m);
    run_frame(m, msum(m), TOT - 1, 0, nc);
    for (int i = 0; i < 8; i++) begin
      rand_mat(m);
      run_frame(m, ($urandom_range(0, 3) == 0) ? W'($urandom) : msum(m),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, TOT - 1) : TOT, 30, nc);
    end
    rand_mat(m);
    run_frame(m, msum(m), TOT, 0, nc);
`ifdef CHECKSUM_EN
    for (int k = 0; k < N; k++) m[k] = W'(k + 1);
    run_frame(m, 4'h8, TOT, 0, nc);
    check("csum_good", 64'(phi_out), 64'(ref_phi));
    run_frame(m, 4'h7, TOT, 0, nc);
    check("csum_bad_hold", 64'(phi_out), 64'(ref_phi));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/synapse_matrix_loader.md
# synapse_matrix_loader

Parametrised serial-to-parallel loader for the synapse block's coupling/phase matrix. It accepts an MSB-first serial bitstream of ROWS×COLS elements, each WIDTH bits, with frame start and per-bit valid qualification. It presents the full matrix as a flat, double-buffered `phi_out` word to the neuron array. It generalises the fixed 5×3×4-bit control-to-neuron path with framing, stalls, abort handling and an optional checksum.

## Interface
- ROWS, default 5: matrix rows.
- COLS, default 3: matrix columns.
- WIDTH, default 4: bits per element.
- N (localparam) = ROWS*COLS; IDXW (localparam) = max(1, $clog2(N)).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is accepted this cycle.
- frame_start  in  1  one-cycle pulse marking the first bit of a frame.
- phi_out  out  N*WIDTH  committed matrix. Element k (row-major, k = r*COLS+c) occupies phi_out[(k+1)*WIDTH-1 -: WIDTH].
- phi_valid  out  1  one-cycle pulse when phi_out is updated.
- frame_err  out  1  one-cycle pulse on an aborted or bad-checksum frame.
- busy  out  1  high while a frame is in progress.
- elem_idx  out  IDXW  index of the element currently being shifted.

## Operation
- States: IDLE, SHIFT, CSUM (CSUM exists only with CHECKSUM_EN).
- IDLE:
  - bit_valid without frame_start is ignored.
  - frame_start → SHIFT. If bit_valid is also high, that bit is payload bit 0.
- SHIFT:
  - Each bit_valid cycle shifts bit_in into the staging element, MSB first, and increments the bit counter 0..WIDTH-1.
  - On bit WIDTH-1, the element is written to staging[k], elem_idx increments and the bit counter clears.
  - Cycles with bit_valid low hold all state (stall).
- Frame completion:
  - The accepting edge is the one that takes payload bit N*WIDTH-1, or the checksum's last bit with CHECKSUM_EN.
  - On that edge, phi_out is loaded from staging (the last element merged directly), phi_valid=1 for one cycle, and the state returns to IDLE.
- Abort: frame_start in SHIFT/CSUM → frame_err pulse, phi_out unchanged, staging discarded, restart at bit 0. If bit_valid is high, that bit is payload bit 0 of the new frame.
- phi_out changes only on a successful frame. Staging is separate, so phi_out is stable during loading (double buffer).
- busy = (state != IDLE). elem_idx is 0 in IDLE.

## Timing
- Reset values: phi_out=0, phi_valid=0, frame_err=0, busy=0, elem_idx=0, state IDLE, counters 0.
- Latency: phi_out/phi_valid are registered on the same edge that accepts the final bit and are visible in the following cycle.
- Minimum frame length: N*WIDTH valid cycles (+WIDTH with checksum). A new frame_start is legal in the cycle after phi_valid.
- rst mid-frame: immediate return to reset values; the partial frame is lost; no frame_err.
- frame_start and last bit in the same cycle: abort wins; that frame is not committed.

## Configuration
- CHECKSUM_EN defined:
  - After the payload, state CSUM receives WIDTH further bits, MSB first.
  - Expected value = sum of all N elements mod 2^WIDTH, accumulated per completed element.
  - Match → commit as above. Mismatch → frame_err pulse, phi_out held, IDLE.
- CHECKSUM_EN undefined: no CSUM state and no accumulator; the frame ends after the last payload bit.

## Structure
- Package synapse_pkg:
  - default ROWS/COLS/WIDTH constants
  - loader state enum
  - element slice index function
  - checksum function
- One sub-module, serial_elem_shift: a WIDTH-bit MSB-first shifter with bit counter, clear, and an elem_done strobe. It is reused for checksum reception.

## Test plan
All scenarios use defaults (N=15, 60 bits).
- Reset: assert rst mid-operation → all outputs 0, state IDLE.
- Basic load: frame_start + 60 bits with each row sent as F,0,0 (bits 1111 0000 0000 ×5) → single phi_valid on edge of bit 59; phi_out = {5{12'h00F}}; elem_idx 0..14 then 0.
- Stalls: same frame with bit_valid low every other cycle → identical phi_out; phi_valid after 119 cycles; busy high throughout.
- Abort: frame_start again at bit 30 → frame_err pulse, phi_out unchanged. The following 60-bit frame of all ones → phi_out all ones.
- Reset mid-frame at bit 20 → no phi_valid and no frame_err; next full frame commits normally.
- CHECKSUM_EN, element k = k+1 (1..15, sum 120):
  - checksum 4'h8 → phi_valid.
  - checksum 4'h7 → frame_err, phi_out held at previous value.
